password_store_arbiter: RTL
===========================

Name: password_store_arbiter

Overview:
Arbitrates single-port access to the 4-digit password store between two requesters: the password setter (write) and the validator (read).
- Uses two-way round-robin arbitration.
- Honours a writer burst lock so that a 4-digit set sequence is never interleaved with validation reads.
- Sits between setter/validator and the store, replacing direct address muxing by setMode.
- All store-side outputs are registered.

Parameters:
- ADDR_WIDTH, 2, store address width (4 entries)
- DATA_WIDTH, 4, digit width

Ports:
- CLK  in  1  clock, all logic on posedge
- RST  in  1  synchronous, active-high reset
- wrReq  in  1  writer requests one write; held until wrAck
- wrLock  in  1  writer burst lock; while 1, reader is never granted
- wrAddr  in  ADDR_WIDTH  write address, stable while wrReq
- wrData  in  DATA_WIDTH  write data, stable while wrReq
- wrAck  out  1  one-cycle pulse: write performed this cycle
- rdReq  in  1  reader requests one read; held until rdValid
- rdAddr  in  ADDR_WIDTH  read address, stable while rdReq
- rdData  out  DATA_WIDTH  read result, held until next read completes
- rdValid  out  1  one-cycle pulse: rdData updated this cycle
- memAddress  out  ADDR_WIDTH  store address (registered)
- memWrite  out  1  store write enable (registered)
- memWData  out  DATA_WIDTH  store write data (registered)
- memRData  in  DATA_WIDTH  store read data, valid 1 cycle after memAddress
- dbgState  out  2  current FSM state
- dbgLastGrant  out  1  0 = writer last granted, 1 = reader last granted

Behaviour:
- Reset (RST=1 at posedge):
  - state=S_IDLE, lastGrant=1 (reader), so the writer wins the first tie.
  - wrAck=0, rdValid=0, memWrite=0, memAddress=0, memWData=0, rdData=0.
  - Any access in flight is abandoned: no ack, no valid, no write after the reset edge.
- FSM states: S_IDLE, S_WRITE, S_READ, S_READ_WAIT.
- S_IDLE, grant decision on the sampled wrReq, rdReq and wrLock:
  - wrLock=1: grant writer if wrReq, else stay idle; rdReq is ignored and stays pending.
  - Only one request: grant it.
  - Both requests: grant the requester not equal to lastGrant.
  - Grant writer: register memAddress=wrAddr, memWData=wrData, memWrite=1; go to S_WRITE; lastGrant=0.
  - Grant reader: register memAddress=rdAddr, memWrite=0; go to S_READ; lastGrant=1.
- S_WRITE:
  - memWrite=1 is seen by the store at this cycle's edge.
  - wrAck=1 this cycle.
  - Next: memWrite=0, go to S_IDLE.
- S_READ:
  - The store samples the address.
  - Next: go to S_READ_WAIT.
- S_READ_WAIT:
  - Capture memRData into rdData at the edge ending this cycle.
  - rdValid=1 in the following S_IDLE cycle, aligned with the new rdData.
- Latency from request seen in S_IDLE:
  - Write: wrAck in the 2nd cycle.
  - Read: rdValid in the 4th cycle.
  - Every access returns to S_IDLE, so there is at least one idle cycle between grants.
- Requesters may only drop or change req/addr/data after ack/valid. A granted access always completes; deasserting req mid-access is a protocol violation with no special handling.
- wrLock changes take effect only at the next S_IDLE decision; an already granted read completes.
- wrAck and rdValid are never asserted in the same cycle.
- memWrite is never 1 outside the S_WRITE cycle.
- No address arithmetic; addresses pass through unmodified, full range 0..2^ADDR_WIDTH-1.

Decomposition:
- lock_pkg:
  - ArbState enum (S_IDLE, S_WRITE, S_READ, S_READ_WAIT, 2-bit)
  - Requester enum (REQ_WRITER=0, REQ_READER=1)
  - default DATA_WIDTH/ADDR_WIDTH constants
- One sub-module, rr_pick2: combinational two-way round-robin picker.
  - Inputs: req[1:0], lastGrant, mask (reader masked by wrLock).
  - Outputs: grantValid, grantId.
- FSM and registers stay in password_store_arbiter.

Test Plan:
- Reset then idle: RST=1 for 2 cycles, no reqs -> all outputs 0, dbgState=S_IDLE, dbgLastGrant=1.
- Single write: wrReq=1, wrAddr=2, wrData=9 -> next cycle memWrite=1, memAddress=2, memWData=9, wrAck=1; following cycle memWrite=0.
- Single read after store holds 7 at addr 3: rdReq=1, rdAddr=3 -> rdValid=1 with rdData=7 exactly 3 cycles after the S_IDLE decision; rdData stays 7 afterwards.
- Simultaneous wrReq and rdReq held continuously after reset -> grants alternate W,R,W,R; the first grant is the writer; dbgLastGrant toggles per grant.
- Burst lock: wrLock=1, rdReq=1, writer issues addresses 0..3 back-to-back -> four wrAcks, no rdValid. After wrLock=0 -> read is granted at the next S_IDLE.
- Reset mid-read: assert RST in the S_READ cycle -> no rdValid ever, state S_IDLE; a re-issued rdReq completes normally.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared types and default widths for the password store arbiter.
package lock_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 2;
  localparam int DEFAULT_DATA_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITE     = 2'd1,
    S_READ      = 2'd2,
    S_READ_WAIT = 2'd3
  } ArbState;

  typedef enum logic {
    REQ_WRITER = 1'b0,
    REQ_READER = 1'b1
  } Requester;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker; the reader request can be masked by the writer burst lock.
module rr_pick2
  import lock_pkg::*;
(
  input  logic [1:0] req,
  input  logic       lastGrant,
  input  logic       mask,
  output logic       grantValid,
  output Requester   grantId
);

  logic [1:0] effReq;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    effReq     = {req[1] & ~mask, req[0]};
    grantValid = |effReq;
    if (&effReq)
      grantId = (lastGrant == REQ_READER) ? REQ_WRITER : REQ_READER;
    else
      grantId = effReq[1] ? REQ_READER : REQ_WRITER;
  end

endmodule

// File: rtl/password_store_arbiter.sv
// Single-port arbiter between the password setter (write) and validator (read);
// every access returns to S_IDLE, and all store-side outputs are registered.
module password_store_arbiter
  import lock_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  wrReq,
  input  logic                  wrLock,
  input  logic [ADDR_WIDTH-1:0] wrAddr,
  input  logic [DATA_WIDTH-1:0] wrData,
  output logic                  wrAck,
  input  logic                  rdReq,
  input  logic [ADDR_WIDTH-1:0] rdAddr,
  output logic [DATA_WIDTH-1:0] rdData,
  output logic                  rdValid,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic                  memWrite,
  output logic [DATA_WIDTH-1:0] memWData,
  input  logic [DATA_WIDTH-1:0] memRData,
  output logic [1:0]            dbgState,
  output logic                  dbgLastGrant
);

  ArbState  state;
  Requester lastGrant;
  logic     grantValid;
  Requester grantId;

  rr_pick2 picker (
    .req       ({rdReq, wrReq}),
    .lastGrant (lastGrant),
    .mask      (wrLock),
    .grantValid(grantValid),
    .grantId   (grantId)
  );

  // wrAck and memWrite are raised together on the grant edge so both are
  // visible for exactly the one S_WRITE cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      lastGrant  <= REQ_READER;
      wrAck      <= 1'b0;
      rdValid    <= 1'b0;
      memWrite   <= 1'b0;
      memAddress <= '0;
      memWData   <= '0;
      rdData     <= '0;
    end else begin
      wrAck    <= 1'b0;
      rdValid  <= 1'b0;
      memWrite <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grantValid) begin
            if (grantId == REQ_WRITER) begin
              memAddress <= wrAddr;
              memWData   <= wrData;
              memWrite   <= 1'b1;
              wrAck      <= 1'b1;
              lastGrant  <= REQ_WRITER;
              state      <= S_WRITE;
            end else begin
              memAddress <= rdAddr;
              lastGrant  <= REQ_READER;
              state      <= S_READ;
            end
          end
        end
        S_WRITE:     state <= S_IDLE;
        S_READ:      state <= S_READ_WAIT;
        S_READ_WAIT: begin
          rdData  <= memRData;
          rdValid <= 1'b1;
          state   <= S_IDLE;
        end
        default:     state <= S_IDLE;
      endcase
    end
  end

  assign dbgState     = state;
  assign dbgLastGrant = lastGrant;

endmodule
